// File: rtl/demux4to1_dispatch_if.sv
`default_nettype none
// ============================================================================
//  Module   : demux4to1_dispatch_if
//  Purpose  : Bundles the source-side and sink-side handshake/data signals of
//             the 1-to-4 dispatcher.
//  Modports : master - source/sink side (drives in_valid, switch, in_data,
//                      out_ready; observes everything else)
//             slave  - dispatcher side
//  Signals  : in_valid/in_ready/switch/in_data   source handshake + word
//             out_valid[3:0]/out_ready[3:0]      per-sink handshake
//             output1..output4                   sink holding registers
//             count                              accepted-word counter
//  Revision : 1.0 - initial release
// ============================================================================
interface demux4to1_dispatch_if #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           switch;
  logic [WIDTH-1:0]     in_data;
  logic [3:0]           out_valid;
  logic [3:0]           out_ready;
  logic [WIDTH-1:0]     output1;
  logic [WIDTH-1:0]     output2;
  logic [WIDTH-1:0]     output3;
  logic [WIDTH-1:0]     output4;
  logic [CNT_WIDTH-1:0] count;

  modport master (
    output in_valid, switch, in_data, out_ready,
    input  in_ready, out_valid, output1, output2, output3, output4, count
  );

  modport slave (
    input  in_valid, switch, in_data, out_ready,
    output in_ready, out_valid, output1, output2, output3, output4, count
  );
endinterface
`default_nettype wire

// File: rtl/demux4to1_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : demux4to1_dispatch
//  Purpose  : Routes one WIDTH-bit source word to one of four sinks selected
//             by a 2-bit switch. Each sink owns a one-entry holding register
//             with a valid/ready handshake, so a stalled sink never blocks the
//             other three. A wrapping counter tallies accepted words.
//  Ports    : clk    - single clock, rising edge
//             rst_n  - synchronous, active-low reset
//             dsp    - demux4to1_dispatch_if.slave (source + sink handshakes,
//                      output1..4 holding registers, count)
//  Revision : 1.0 - initial release
// ============================================================================
module demux4to1_dispatch #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  demux4to1_dispatch_if.slave  dsp
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  logic [3:0]            w_full;
  logic [3:0][WIDTH-1:0] w_data;
  logic                  w_ready;
  logic                  w_accept;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  count_d;

  // Readiness is judged only against the channel currently selected: a free
  // slot, or a full slot whose sink is draining this same cycle.
  assign w_ready  = ~w_full[dsp.switch] | dsp.out_ready[dsp.switch];
  assign w_accept = dsp.in_valid & w_ready;

  generate
    for (genvar k = 0; k < 4; k++) begin : g_ch
      state_t           state_q;
      state_t           state_d;
      logic [WIDTH-1:0] data_q;
      logic [WIDTH-1:0] data_d;
      logic             load;
      logic             drain;

      assign load  = w_accept && (dsp.switch == 2'(k));
      assign drain = (state_q == FULL) && dsp.out_ready[k];

      // A load always wins over a drain: drain+refill in one cycle keeps the
      // channel FULL with the new word. The data register only moves on a
      // load, so a drained or idle channel keeps showing its last word.
      always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
          EMPTY: begin
            if (load) begin
              state_d = FULL;
              data_d  = dsp.in_data;
            end
          end
          FULL: begin
            if (load) begin
              state_d = FULL;
              data_d  = dsp.in_data;
            end else if (drain) begin
              state_d = EMPTY;
            end
          end
          default: state_d = EMPTY;
        endcase
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_q <= EMPTY;
          data_q  <= '0;
        end else begin
          state_q <= state_d;
          data_q  <= data_d;
        end
      end

      assign w_full[k] = (state_q == FULL);
      assign w_data[k] = data_q;
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    if (w_accept) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign dsp.in_ready  = w_ready;
  assign dsp.out_valid = w_full;
  assign dsp.output1   = w_data[0];
  assign dsp.output2   = w_data[1];
  assign dsp.output3   = w_data[2];
  assign dsp.output4   = w_data[3];
  assign dsp.count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_demux4to1_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux4to1_dispatch
//  Purpose  : Self-checking bench for demux4to1_dispatch. Stimulus pushes the
//             words it expects each sink to receive into per-channel queues;
//             a monitor pops and compares whenever a sink handshake completes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_demux4to1_dispatch;

  logic clk;
  logic rst_n;

  demux4to1_dispatch_if #(.WIDTH(16), .CNT_WIDTH(8)) dsp ();

  demux4to1_dispatch #(.WIDTH(16), .CNT_WIDTH(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dsp   (dsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] q [4][$];
  int          exp_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] out_of(input int k);
    case (k)
      0:       return dsp.output1;
      1:       return dsp.output2;
      2:       return dsp.output3;
      default: return dsp.output4;
    endcase
  endfunction

  // Monitor: out_valid must mirror the model's queue occupancy; a completed
  // handshake must present the oldest expected word of that channel.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [3:0] ev;
      for (int k = 0; k < 4; k++) ev[k] = (q[k].size() != 0);
      chk("out_valid", {28'd0, dsp.out_valid}, {28'd0, ev});
      for (int k = 0; k < 4; k++) begin
        if (dsp.out_valid[k] && dsp.out_ready[k] && q[k].size() != 0) begin
          logic [15:0] e;
          e = q[k].pop_front();
          chk($sformatf("drain_ch%0d", k + 1), {16'd0, out_of(k)}, {16'd0, e});
        end
      end
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic do_reset(input int n, input bit rnd);
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) q[k].delete();
    exp_count = 0;
    repeat (n) begin
      if (rnd) begin
        dsp.in_valid  = 1'($urandom);
        dsp.switch    = 2'($urandom);
        dsp.in_data   = 16'($urandom);
        dsp.out_ready = 4'($urandom);
      end else begin
        dsp.in_valid  = 1'b0;
        dsp.out_ready = 4'b0000;
      end
      @(posedge clk); #1;
    end
    rst_n         = 1'b1;
    dsp.in_valid  = 1'b0;
    dsp.switch    = 2'b00;
    dsp.in_data   = 16'h0000;
    dsp.out_ready = 4'b0000;
  endtask

  task automatic send(input logic [1:0] sw, input logic [15:0] d, input logic exp_rdy);
    dsp.in_valid = 1'b1;
    dsp.switch   = sw;
    dsp.in_data  = d;
    @(negedge clk);
    chk($sformatf("in_ready_sw%0d", sw), {31'd0, dsp.in_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    if (exp_rdy) begin
      q[sw].push_back(d);
      exp_count++;
    end
    #1;
    dsp.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    dsp.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    dsp.in_valid  = 1'b0;
    dsp.switch    = 2'b00;
    dsp.in_data   = 16'h0000;
    dsp.out_ready = 4'b0000;
    @(posedge clk); #1;

    // 1 Reset with random inputs
    do_reset(2, 1'b1);
    @(negedge clk);
    chk("rst_output1", {16'd0, dsp.output1}, 32'h0);
    chk("rst_output2", {16'd0, dsp.output2}, 32'h0);
    chk("rst_output3", {16'd0, dsp.output3}, 32'h0);
    chk("rst_output4", {16'd0, dsp.output4}, 32'h0);
    chk("rst_count",   {24'd0, dsp.count},   32'h0);
    chk("rst_in_ready", {31'd0, dsp.in_ready}, 32'h1);
    @(posedge clk); #1;

    // 2 Stall / refill on channel 1
    send(2'b00, 16'h1111, 1'b1);
    @(negedge clk);
    chk("t2_output1_1111", {16'd0, dsp.output1}, 32'h1111);
    @(posedge clk); #1;
    send(2'b00, 16'hAAAA, 1'b0);
    dsp.out_ready = 4'b0001;
    send(2'b00, 16'hAAAA, 1'b1);
    @(negedge clk);
    chk("t2_output1_AAAA", {16'd0, dsp.output1}, 32'hAAAA);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_retained", {16'd0, dsp.output1}, 32'hAAAA);
    chk("t2_count", {24'd0, dsp.count}, 32'd2);
    @(posedge clk); #1;
    dsp.out_ready = 4'b0000;

    // 3 Isolation
    do_reset(1, 1'b0);
    send(2'b00, 16'h1111, 1'b1);
    send(2'b01, 16'h2222, 1'b1);
    send(2'b10, 16'h3333, 1'b1);
    send(2'b11, 16'h4444, 1'b1);
    @(negedge clk);
    chk("t3_out_valid", {28'd0, dsp.out_valid}, 32'hF);
    chk("t3_count", {24'd0, dsp.count}, 32'd4);
    @(posedge clk); #1;
    send(2'b01, 16'h5555, 1'b0);
    @(negedge clk);
    chk("t3_count_hold", {24'd0, dsp.count}, 32'd4);
    @(posedge clk); #1;

    // 4 Independence: empty channel 3, keep channel 2 stalled
    dsp.out_ready = 4'b0100;
    idle(1);
    dsp.out_ready = 4'b0000;
    send(2'b01, 16'h9999, 1'b0);
    send(2'b10, 16'h4321, 1'b1);
    send(2'b01, 16'h9999, 1'b0);
    @(negedge clk);
    chk("t4_output2", {16'd0, dsp.output2}, 32'h2222);
    chk("t4_output3", {16'd0, dsp.output3}, 32'h4321);
    chk("t4_count", {24'd0, dsp.count}, 32'd5);
    @(posedge clk); #1;

    // 5 Throughput and counter wrap
    do_reset(1, 1'b0);
    dsp.out_ready = 4'b1111;
    for (int i = 0; i < 300; i++) begin
      send(2'(i % 4), 16'(i * 7 + 5), 1'b1);
    end
    idle(2);
    @(negedge clk);
    chk("t5_count", {24'd0, dsp.count}, 32'h2C);
    chk("t5_model_count", {24'd0, dsp.count}, {24'd0, 8'(exp_count)});
    chk("t5_all_drained", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 32'd0);
    @(posedge clk); #1;

    // 6 Reset mid-operation
    do_reset(1, 1'b0);
    dsp.out_ready = 4'b1010;
    send(2'b01, 16'h0B01, 1'b1);
    send(2'b11, 16'h0D01, 1'b1);
    send(2'b01, 16'h0B02, 1'b1);
    send(2'b00, 16'h0A01, 1'b1);
    send(2'b10, 16'h0C01, 1'b1);
    dsp.out_ready = 4'b0000;
    @(negedge clk);
    chk("t6_pre_valid", {28'd0, dsp.out_valid}, 32'h5);
    chk("t6_pre_count", {24'd0, dsp.count}, 32'd5);
    @(posedge clk); #1;
    do_reset(1, 1'b0);
    @(negedge clk);
    chk("t6_post_valid", {28'd0, dsp.out_valid}, 32'h0);
    chk("t6_post_count", {24'd0, dsp.count}, 32'h0);
    chk("t6_post_output1", {16'd0, dsp.output1}, 32'h0);
    chk("t6_post_output3", {16'd0, dsp.output3}, 32'h0);
    @(posedge clk); #1;
    dsp.out_ready = 4'b1111;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
